multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 252 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: Moore FSM with a memory wait counter.
// Optional feature: define CTRL_JAL_EN to add the jal (link) state.
module multicycle_control #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  output logic [3:0] alu_ctrl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       link,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_LAT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_BEQ  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_RWB      = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
`ifdef CTRL_JAL_EN
    S_JAL      = 4'd10,
`endif
    S_TRAP     = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             illegal_q;
  logic             wait_done;
  logic             is_rtype;
  logic             r_valid;
  logic [3:0]       r_alu;

  logic       pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;
  logic       reg_dst_c, mem_to_reg_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, pc_src_c;
  logic [3:0] alu_ctrl_c;
`ifdef CTRL_JAL_EN
  logic       link_c;
`endif

  assign is_rtype  = (opcode == OP_RTYPE);
  assign wait_done = (wait_q == LAST_WAIT);

  // R-type funct decode: ALU operation and whether funct is a supported ALU op
  always_comb begin
    r_valid = 1'b1;
    r_alu   = ALU_NONE;
    case (funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_AND:  r_alu = ALU_AND;
      FN_NOR:  r_alu = ALU_NOR;
      FN_SLT:  r_alu = ALU_SLT;
      FN_SLL:  r_alu = ALU_SLL;
      default: r_valid = 1'b0;
    endcase
  end

  // Wait counter runs only in FETCH/MEM_RD and is zero on entry to either
  always_comb begin
    wait_d = '0;
    if ((state_q == S_FETCH || state_q == S_MEM_RD) && !wait_done)
      wait_d = wait_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
    end
  end

  // Next state and Moore outputs (pc_write in BRANCH also follows alu_zero)
  always_comb begin
    state_d      = state_q;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    pc_src_c     = 2'b00;
    alu_ctrl_c   = ALU_NONE;
`ifdef CTRL_JAL_EN
    link_c       = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        alu_ctrl_c  = ALU_ADD;
        if (wait_done) begin
          pc_write_c = 1'b1;
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        alu_ctrl_c  = ALU_ADD;
        case (opcode)
          OP_RTYPE: begin
            if (r_valid)              state_d = S_EXEC;
            else if (funct == FN_JR)  state_d = S_JUMP;
            else                      state_d = S_TRAP;
          end
          OP_ADDI, OP_ANDI: state_d = S_EXEC;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
`ifdef CTRL_JAL_EN
          OP_JAL:           state_d = S_JAL;
`endif
          default:          state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        if (is_rtype) begin
          alu_src_b_c = 2'b00;
          alu_ctrl_c  = r_alu;
        end else begin
          alu_src_b_c = 2'b10;
          alu_ctrl_c  = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
        end
        state_d = S_RWB;
      end
      S_RWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = is_rtype;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_ctrl_c  = ALU_ADD;
        state_d     = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read_c = 1'b1;
        if (wait_done) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_ctrl_c  = ALU_BEQ;
        pc_src_c    = 2'b01;
        pc_write_c  = alu_zero;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = is_rtype ? 2'b11 : 2'b10;
        state_d    = S_FETCH;
      end
`ifdef CTRL_JAL_EN
      S_JAL: begin
        pc_write_c  = 1'b1;
        pc_src_c    = 2'b10;
        reg_write_c = 1'b1;
        link_c      = 1'b1;
        state_d     = S_FETCH;
      end
`endif
      default: state_d = S_TRAP;
    endcase
  end

  // Write enables are forced low while reset is held
  assign pc_write   = pc_write_c & rst_n;
  assign ir_write   = ir_write_c & rst_n;
  assign mem_write  = mem_write_c & rst_n;
  assign reg_write  = reg_write_c & rst_n;
  assign mem_read   = mem_read_c;
  assign reg_dst    = reg_dst_c;
  assign mem_to_reg = mem_to_reg_c;
  assign alu_src_a  = alu_src_a_c;
  assign alu_src_b  = alu_src_b_c;
  assign pc_src     = pc_src_c;
  assign alu_ctrl   = alu_ctrl_c;
  assign state      = state_q;
  assign illegal    = illegal_q;
`ifdef CTRL_JAL_EN
  assign link       = link_c;
`else
  assign link       = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: MEM_LAT=1 and MEM_LAT=3 instances checked each cycle
// against an instruction-level model; honours CTRL_JAL_EN.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] alu;
    logic       a;
    logic [1:0] b;
    logic [1:0] pcs;
    logic       pcw, irw, mr, mw, rw, rd, m2r, lnk, ill;
  } out_t;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC = 4'd2, RWB = 4'd3,
                         MADDR = 4'd4, MRD = 4'd5, MWB = 4'd6, MWR = 4'd7,
                         BRANCH = 4'd8, JUMP = 4'd9, JAL = 4'd10, TRAP = 4'd15;
  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4,
                 C_J = 5, C_JR = 6, C_JAL = 7, C_BAD = 8;
  localparam logic [3:0] LW_SEQ [9] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd6};
  localparam logic [3:0] ADD_SEQ [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

  logic       clk, rst_n, alu_zero;
  logic [5:0] opcode, funct;

  logic [3:0] d1_alu_ctrl, d1_state, d3_alu_ctrl, d3_state;
  logic [1:0] d1_alu_src_b, d1_pc_src, d3_alu_src_b, d3_pc_src;
  logic d1_alu_src_a, d1_pc_write, d1_ir_write, d1_mem_read, d1_mem_write, d1_reg_write;
  logic d1_reg_dst, d1_mem_to_reg, d1_link, d1_illegal;
  logic d3_alu_src_a, d3_pc_write, d3_ir_write, d3_mem_read, d3_mem_write, d3_reg_write;
  logic d3_reg_dst, d3_mem_to_reg, d3_link, d3_illegal;

  multicycle_control #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .alu_ctrl(d1_alu_ctrl), .alu_src_a(d1_alu_src_a), .alu_src_b(d1_alu_src_b),
    .pc_write(d1_pc_write), .ir_write(d1_ir_write), .mem_read(d1_mem_read),
    .mem_write(d1_mem_write), .reg_write(d1_reg_write), .reg_dst(d1_reg_dst),
    .mem_to_reg(d1_mem_to_reg), .link(d1_link), .pc_src(d1_pc_src),
    .state(d1_state), .illegal(d1_illegal));

  multicycle_control #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .alu_ctrl(d3_alu_ctrl), .alu_src_a(d3_alu_src_a), .alu_src_b(d3_alu_src_b),
    .pc_write(d3_pc_write), .ir_write(d3_ir_write), .mem_read(d3_mem_read),
    .mem_write(d3_mem_write), .reg_write(d3_reg_write), .reg_dst(d3_reg_dst),
    .mem_to_reg(d3_mem_to_reg), .link(d3_link), .pc_src(d3_pc_src),
    .state(d3_state), .illegal(d3_illegal));

  out_t act1, act3, exp1, exp3;
  assign act1 = {d1_state, d1_alu_ctrl, d1_alu_src_a, d1_alu_src_b, d1_pc_src, d1_pc_write,
                 d1_ir_write, d1_mem_read, d1_mem_write, d1_reg_write, d1_reg_dst,
                 d1_mem_to_reg, d1_link, d1_illegal};
  assign act3 = {d3_state, d3_alu_ctrl, d3_alu_src_a, d3_alu_src_b, d3_pc_src, d3_pc_write,
                 d3_ir_write, d3_mem_read, d3_mem_write, d3_reg_write, d3_reg_dst,
                 d3_mem_to_reg, d3_link, d3_illegal};

  int    checks = 0, errors = 0;
  int    clr_req = 0, clr_seen = 0;
  logic  chk_en = 1'b0;
  string tname = "init";
  out_t  tr1[$], tr3[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic int iclass(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b100000 || fn == 6'b100100 || fn == 6'b100111 ||
            fn == 6'b101010 || fn == 6'b000000) return C_R;
        if (fn == 6'b001000) return C_JR;
        return C_BAD;
      end
      6'b001000, 6'b001100: return C_I;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000010: return C_J;
`ifdef CTRL_JAL_EN
      6'b000011: return C_JAL;
`endif
      default: return C_BAD;
    endcase
  endfunction

  // Instruction latency table in cycles
  function automatic int ilen(input int cls, input int lat);
    case (cls)
      C_R, C_I, C_SW: return 3 + lat;
      C_LW:           return 3 + 2 * lat;
      default:        return 2 + lat;
    endcase
  endfunction

  function automatic out_t rst_vec();
    out_t e = '0;
    e.alu = 4'b0010;
    e.b   = 2'b01;
    e.mr  = 1'b1;
    return e;
  endfunction

  // Expected outputs k cycles after reset release, with the instruction repeated back to back
  function automatic out_t expect_at(input logic [5:0] op, input logic [5:0] fn,
                                     input logic z, input int lat, input int k);
    out_t e = '0;
    int cls = iclass(op, fn);
    int pos, r, fidx = 0;
    logic [3:0] st;
    pos = (cls == C_BAD) ? k : k % ilen(cls, lat);
    if (pos < lat) begin
      st = FETCH; fidx = pos;
    end else if (pos == lat) begin
      st = DECODE;
    end else begin
      r = pos - lat - 1;
      case (cls)
        C_R, C_I: st = (r == 0) ? EXEC : RWB;
        C_LW:     st = (r == 0) ? MADDR : ((r <= lat) ? MRD : MWB);
        C_SW:     st = (r == 0) ? MADDR : MWR;
        C_BEQ:    st = BRANCH;
        C_J, C_JR: st = JUMP;
        C_JAL:    st = JAL;
        default:  st = TRAP;
      endcase
    end
    e.st = st;
    case (st)
      FETCH: begin
        e.mr = 1'b1; e.b = 2'b01; e.alu = 4'b0010;
        e.pcw = (fidx == lat - 1); e.irw = (fidx == lat - 1);
      end
      DECODE: begin e.b = 2'b11; e.alu = 4'b0010; end
      EXEC: begin
        e.a = 1'b1;
        if (cls == C_R) begin
          case (fn)
            6'b100000: e.alu = 4'b0010;
            6'b100100: e.alu = 4'b0101;
            6'b100111: e.alu = 4'b0111;
            6'b101010: e.alu = 4'b1011;
            default:   e.alu = 4'b0100;
          endcase
        end else begin
          e.b = 2'b10;
          e.alu = (op == 6'b001100) ? 4'b0101 : 4'b0010;
        end
      end
      RWB:   begin e.rw = 1'b1; e.rd = (cls == C_R); end
      MADDR: begin e.a = 1'b1; e.b = 2'b10; e.alu = 4'b0010; end
      MRD:   e.mr = 1'b1;
      MWB:   begin e.rw = 1'b1; e.m2r = 1'b1; end
      MWR:   e.mw = 1'b1;
      BRANCH: begin e.a = 1'b1; e.alu = 4'b1000; e.pcs = 2'b01; e.pcw = z; end
      JUMP:  begin e.pcw = 1'b1; e.pcs = (cls == C_JR) ? 2'b11 : 2'b10; end
      JAL:   begin e.pcw = 1'b1; e.pcs = 2'b10; e.rw = 1'b1; e.lnk = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Compare process: both instances against the model on every falling edge
  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      tr1.delete();
      tr3.delete();
      clr_seen = clr_req;
    end
    if (chk_en) begin
      check($sformatf("%s dut1 c%0d rst_n=%0b", tname, tr1.size(), rst_n), 32'(act1), 32'(exp1));
      check($sformatf("%s dut3 c%0d rst_n=%0b", tname, tr3.size(), rst_n), 32'(act3), 32'(exp3));
      if (rst_n) begin
        tr1.push_back(act1);
        tr3.push_back(act3);
      end
    end
  end

  task automatic run_test(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int n);
    rst_n = 1'b0;
    opcode = op; funct = fn; alu_zero = z; tname = name;
    clr_req++;
    exp1 = rst_vec(); exp3 = rst_vec();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp1 = expect_at(op, fn, z, 1, k);
      exp3 = expect_at(op, fn, z, 3, k);
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0;

    run_test("add", 6'b000000, 6'b100000, 1'b0, 12);
    for (int i = 0; i < 5; i++) check($sformatf("add seq %0d", i), 32'(tr1[i].st), 32'(ADD_SEQ[i]));
    check("add exec alu", 32'(tr1[2].alu), 32'h2);
    check("add rwb rw/rd", 32'({tr1[3].rw, tr1[3].rd}), 32'h3);
    cnt = 0;
    for (int i = 0; i < 4; i++) cnt += int'(tr1[i].rw);
    check("add rw cycles", 32'(cnt), 32'd1);

    run_test("and", 6'b000000, 6'b100100, 1'b0, 6);
    run_test("nor", 6'b000000, 6'b100111, 1'b0, 6);
    run_test("slt", 6'b000000, 6'b101010, 1'b0, 6);
    run_test("sll", 6'b000000, 6'b000000, 1'b0, 6);
    run_test("addi", 6'b001000, 6'b010101, 1'b0, 8);
    run_test("andi", 6'b001100, 6'b000001, 1'b0, 8);
    run_test("rbad", 6'b000000, 6'b111111, 1'b0, 8);

    run_test("jr", 6'b000000, 6'b001000, 1'b0, 8);
    check("jr state/pcs", 32'({tr1[2].st, tr1[2].pcs}), 32'({4'd9, 2'b11}));
    run_test("j", 6'b000010, 6'b000000, 1'b0, 8);

    run_test("lw", 6'b100011, 6'b000000, 1'b0, 18);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("lw seq %0d", i), 32'(tr3[i].st), 32'(LW_SEQ[i]));
      cnt += int'(tr3[i].mr);
    end
    check("lw mem_read cycles", 32'(cnt), 32'd6);
    check("lw wb rw/m2r/rd", 32'({tr3[8].rw, tr3[8].m2r, tr3[8].rd}), 32'b110);

    run_test("beq1", 6'b000100, 6'b000000, 1'b1, 8);
    check("beq1 pcw/pcs", 32'({tr1[2].pcw, tr1[2].pcs}), 32'b101);
    check("beq1 back to fetch", 32'(tr1[3].st), 32'd0);
    run_test("beq0", 6'b000100, 6'b000000, 1'b0, 8);
    check("beq0 pcw", 32'(tr1[2].pcw), 32'd0);
    check("beq0 back to fetch", 32'(tr1[3].st), 32'd0);

    run_test("jal", 6'b000011, 6'b000000, 1'b0, 10);
`ifdef CTRL_JAL_EN
    check("jal state", 32'(tr1[2].st), 32'd10);
    check("jal link/rw", 32'({tr1[2].lnk, tr1[2].rw}), 32'b11);
`else
    check("jal state", 32'(tr1[2].st), 32'd15);
    check("jal illegal", 32'(tr1[2].ill), 32'd1);
`endif

    run_test("trap", 6'b111111, 6'b000000, 1'b0, 25);
    cnt = 0;
    for (int i = 0; i < 25; i++) cnt += int'(tr3[i].ill);
    check("trap illegal cycles", 32'(cnt), 32'd21);
    check("trap last state", 32'(tr3[24].st), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    check("trap async rst dut1", 32'({d1_state, d1_illegal}), 32'd0);
    check("trap async rst dut3", 32'({d3_state, d3_illegal}), 32'd0);

    run_test("sw1", 6'b101011, 6'b000000, 1'b0, 3);
    check("sw1 in mem_wr", 32'({d1_state, d1_mem_write}), 32'({4'd7, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    check("sw1 async rst", 32'({d1_state, d1_mem_write}), 32'd0);

    run_test("sw3", 6'b101011, 6'b000000, 1'b0, 5);
    check("sw3 in mem_wr", 32'({d3_state, d3_mem_write}), 32'({4'd7, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    check("sw3 async rst", 32'({d3_state, d3_mem_write}), 32'd0);

    run_test("add2", 6'b000000, 6'b100000, 1'b0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
